// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART-to-imem boot loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMMIT,
    DONE
  } state_t;

  localparam logic [31:0] END_MARKER_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD     = 4;
  localparam int          BYTE_IDX_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/uart_imem_loader_if.sv
// Bundles the UART receive inputs and the imem write port of the boot loader.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // The loader drives the imem port and consumes the UART bytes.
  modport master (
    input  rx_valid, rx_data, rx_break,
    output imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data, rx_break,
    input  imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_imem_loader_byte_assembler.sv
// Detects rising edges of rx_valid and packs bytes little-endian into a 32-bit word.
module byte_assembler
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_break,
  output logic [31:0] o_word,
  output logic        o_word_valid_pulse
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic                        r_rx_valid_q;
  logic [BYTE_IDX_W-1:0]       r_byte_idx;
  logic [8*BYTES_PER_WORD-1:0] r_word;
  logic                        w_break;
  logic                        w_accept;

  // A BREAK wins over a byte whose rising edge lands in the same cycle.
  assign w_break  = i_en && i_rx_break;
  assign w_accept = i_en && i_rx_valid && !r_rx_valid_q && !i_rx_break;

  assign o_word             = r_word;
  assign o_word_valid_pulse = w_accept && (r_byte_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid_q <= 1'b0;
      r_byte_idx   <= '0;
      r_word       <= '0;
    end else begin
      r_rx_valid_q <= i_rx_valid;
      if (w_break) begin
        r_byte_idx <= '0;
        r_word     <= '0;
      end else if (w_accept) begin
        r_word[8*r_byte_idx +: 8] <= i_rx_data;
        r_byte_idx                <= r_byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: writes UART-received words to imem from address 0 and holds the
// core in reset until the end marker arrives or imem is full.
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] END_MARKER = END_MARKER_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  uart_imem_loader_if.master  bus,
  output logic                write_done,
  output logic                overflow,
  output logic                core_rst,
  output logic [ADDR_W:0]     word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_write_done;
  logic              r_overflow;
  logic              r_core_rst;
  logic              w_we;
  logic              w_last_addr;
  logic [31:0]       w_word;
  logic              w_word_valid;

  byte_assembler u_byte_assembler (
    .clk                (clk),
    .rst                (rst),
    .i_en               (r_state != DONE),
    .i_rx_valid         (bus.rx_valid),
    .i_rx_data          (bus.rx_data),
    .i_rx_break         (bus.rx_break),
    .o_word             (w_word),
    .o_word_valid_pulse (w_word_valid)
  );

  assign w_last_addr = (r_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    unique case (r_state)
      LOAD: if (w_word_valid) w_state_next = COMMIT;
      COMMIT: begin
        if (w_word == END_MARKER) begin
          w_state_next = DONE;
        end else begin
          w_we         = 1'b1;
          w_state_next = w_last_addr ? DONE : LOAD;
        end
      end
      DONE:    w_state_next = DONE;
      default: w_state_next = LOAD;
    endcase
  end

  // The address saturates at the last word; it never wraps over written code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_word_count <= '0;
      r_write_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_core_rst   <= 1'b1;
    end else if (r_state == COMMIT) begin
      if (w_we) begin
        r_word_count <= r_word_count + 1'b1;
        if (w_last_addr) r_overflow <= 1'b1;
        else             r_addr     <= r_addr + 1'b1;
      end
      if (w_state_next == DONE) begin
        r_write_done <= 1'b1;
        r_core_rst   <= 1'b0;
      end
    end
  end

  assign bus.imem_we    = w_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_word;
  assign write_done     = r_write_done;
  assign overflow       = r_overflow;
  assign core_rst       = r_core_rst;
  assign word_count     = r_word_count;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench: an 8-bit-address loader for the main flows and a 2-bit one
// sharing the same stimulus to exercise the full-memory stop.
module tb_uart_imem_loader;
  import uart_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_break = 1'b0;

  always #5 clk = ~clk;

  uart_imem_loader_if #(.ADDR_W(8)) bus8 ();
  uart_imem_loader_if #(.ADDR_W(2)) bus2 ();

  assign bus8.rx_valid = rx_valid;
  assign bus8.rx_data  = rx_data;
  assign bus8.rx_break = rx_break;
  assign bus2.rx_valid = rx_valid;
  assign bus2.rx_data  = rx_data;
  assign bus2.rx_break = rx_break;

  logic       done8, ovf8, crst8;
  logic [8:0] wc8;
  logic       done2, ovf2, crst2;
  logic [2:0] wc2;

  uart_imem_loader #(.ADDR_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus8.master),
    .write_done (done8),
    .overflow   (ovf8),
    .core_rst   (crst8),
    .word_count (wc8)
  );

  uart_imem_loader #(.ADDR_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2.master),
    .write_done (done2),
    .overflow   (ovf2),
    .core_rst   (crst2),
    .word_count (wc2)
  );

  int checks   = 0;
  int failures = 0;

  // Write monitor, sampled just after the falling edge.
  int          n_we8 = 0;
  logic [1:0]  log2_addr[$];
  logic [31:0] log2_data[$];

  always @(negedge clk) begin
    #1;
    if (bus8.imem_we === 1'b1) n_we8++;
    if (bus2.imem_we === 1'b1) begin
      log2_addr.push_back(bus2.imem_addr);
      log2_data.push_back(bus2.imem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a word LSB first; checks the 8-bit loader's write one cycle after the 4th byte.
  task automatic send_word(input logic [31:0] w, input int hold, input logic exp_we,
                           input logic [7:0] exp_addr, input logic [31:0] exp_data,
                           input string tag);
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], hold);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = w[31:24];
    @(negedge clk);
    check({tag, " imem_we"}, 32'(bus8.imem_we), 32'(exp_we));
    if (exp_we) begin
      check({tag, " imem_addr"}, 32'(bus8.imem_addr), 32'(exp_addr));
      check({tag, " imem_wdata"}, bus8.imem_wdata, exp_data);
    end
    repeat (hold - 1) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic        rst_before;
    logic [31:0] word;
    int          hold;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic [8:0]  exp_wc;
    logic        exp_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_we;
    int base_log;

    tbl[0] = '{1'b1, 32'hFE01_0113, 1,  1'b1, 8'd0, 32'hFE01_0113, 9'd1, 1'b0};
    tbl[1] = '{1'b0, 32'hFFFF_FFFF, 1,  1'b0, 8'd0, 32'h0,         9'd1, 1'b1};
    tbl[2] = '{1'b1, 32'h0000_0000, 1,  1'b1, 8'd0, 32'h0000_0000, 9'd1, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0000, 1,  1'b1, 8'd1, 32'h0000_0000, 9'd2, 1'b0};
    tbl[4] = '{1'b0, 32'h0081_2E23, 1,  1'b1, 8'd2, 32'h0081_2E23, 9'd3, 1'b0};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF, 1,  1'b0, 8'd0, 32'h0,         9'd3, 1'b1};
    tbl[6] = '{1'b1, 32'hA5C3_0F1E, 20, 1'b1, 8'd0, 32'hA5C3_0F1E, 9'd1, 1'b0};

    // Reset values
    do_reset();
    check("rst imem_we",    32'(bus8.imem_we),    32'd0);
    check("rst imem_addr",  32'(bus8.imem_addr),  32'd0);
    check("rst imem_wdata", bus8.imem_wdata,      32'd0);
    check("rst write_done", 32'(done8),           32'd0);
    check("rst overflow",   32'(ovf8),            32'd0);
    check("rst core_rst",   32'(crst8),           32'd1);
    check("rst word_count", 32'(wc8),             32'd0);

    // Table: first-word/marker flow, multi-word load, held rx_valid
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].rst_before) do_reset();
      send_word(tbl[v].word, tbl[v].hold, tbl[v].exp_we, tbl[v].exp_addr,
                tbl[v].exp_data, $sformatf("vec%0d", v));
      @(negedge clk);
      check($sformatf("vec%0d word_count", v), 32'(wc8),   32'(tbl[v].exp_wc));
      check($sformatf("vec%0d write_done", v), 32'(done8), 32'(tbl[v].exp_done));
      check($sformatf("vec%0d core_rst", v),   32'(crst8), 32'(!tbl[v].exp_done));
      check($sformatf("vec%0d overflow", v),   32'(ovf8),  32'd0);
    end

    // Reset in the middle of word 2, then reload from address 0
    send_byte(8'h11, 20);
    send_byte(8'h22, 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst imem_addr",  32'(bus8.imem_addr), 32'd0);
    check("midrst word_count", 32'(wc8),            32'd0);
    check("midrst core_rst",   32'(crst8),          32'd1);
    send_word(32'hDEAD_BEEF, 1, 1'b1, 8'd0, 32'hDEAD_BEEF, "reload");
    @(negedge clk);
    check("reload word_count", 32'(wc8), 32'd1);
    send_word(32'hFFFF_FFFF, 1, 1'b0, 8'd0, 32'h0, "reload marker");
    @(negedge clk);
    check("reload write_done", 32'(done8), 32'd1);
    check("reload core_rst",   32'(crst8), 32'd0);

    // Bytes after write_done are ignored
    base_we = n_we8;
    send_word(32'h1234_5678, 1, 1'b0, 8'd0, 32'h0, "after done");
    repeat (3) @(negedge clk);
    check("after done writes",     32'(n_we8 - base_we), 32'd0);
    check("after done imem_addr",  32'(bus8.imem_addr),  32'd1);
    check("after done imem_wdata", bus8.imem_wdata,      32'hFFFF_FFFF);
    check("after done word_count", 32'(wc8),             32'd1);
    check("after done write_done", 32'(done8),           32'd1);
    check("after done core_rst",   32'(crst8),           32'd0);

    // BREAK discards a partial word
    do_reset();
    send_byte(8'h93, 1);
    send_byte(8'h07, 1);
    @(negedge clk);
    rx_break = 1'b1;
    @(negedge clk);
    rx_break = 1'b0;
    send_word(32'h0081_2E23, 1, 1'b1, 8'd0, 32'h0081_2E23, "break");
    @(negedge clk);
    check("break word_count", 32'(wc8), 32'd1);

    // Memory full on the 2-bit loader: four writes, then stop
    do_reset();
    base_log = log2_addr.size();
    for (int k = 0; k < 5; k++) begin
      send_word(32'h1111_0000 + 32'(k), 1, 1'b1, 8'(k), 32'h1111_0000 + 32'(k),
                $sformatf("fill%0d", k));
      @(negedge clk);
      if (k >= 3) begin
        check($sformatf("fill%0d overflow", k),   32'(ovf2),  32'd1);
        check($sformatf("fill%0d write_done", k), 32'(done2), 32'd1);
        check($sformatf("fill%0d core_rst", k),   32'(crst2), 32'd0);
      end else begin
        check($sformatf("fill%0d overflow", k),   32'(ovf2),  32'd0);
        check($sformatf("fill%0d core_rst", k),   32'(crst2), 32'd1);
      end
    end
    repeat (2) @(negedge clk);
    check("fill write count", 32'(log2_addr.size() - base_log), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base_log + i < log2_addr.size()) begin
        check($sformatf("fill log%0d addr", i), 32'(log2_addr[base_log + i]), 32'(i));
        check($sformatf("fill log%0d data", i), log2_data[base_log + i], 32'h1111_0000 + 32'(i));
      end
    end
    check("fill word_count", 32'(wc2),            32'd4);
    check("fill imem_addr",  32'(bus2.imem_addr), 32'd3);
    check("fill imem_we",    32'(bus2.imem_we),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Boot-time controller between the UART receiver and the instruction memory. It assembles received bytes into 32-bit little-endian instruction words and writes them to sequential imem addresses from 0. It stops on the end marker word and then releases the core from reset. While loading, it owns the imem write port and holds the core in reset.

Parameters:
ADDR_W, 8, imem word-address width; capacity DEPTH = 2**ADDR_W words
END_MARKER, 32'hFFFF_FFFF, word value that terminates loading and is never written

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  UART byte-valid; level or pulse, each rising edge = one byte
rx_data  in  8  UART received byte, stable while rx_valid high
rx_break  in  1  UART BREAK detected
imem_we  out  1  imem write strobe, one cycle per word
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  32  imem write data
write_done  out  1  loading finished, sticky until rst
overflow  out  1  imem filled before END_MARKER, sticky until rst
core_rst  out  1  active-high reset to the CPU core; high until write_done
word_count  out  ADDR_W+1  number of words written

Behaviour:
- Clock, reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0, write_done=0, overflow=0, core_rst=1, word_count=0.
  - Internal state: byte_idx=0, rx_valid_q=0, state=LOAD.
- Byte accept: a byte is taken in a cycle where rx_valid=1 and rx_valid_q=0. rx_valid_q is the registered rx_valid.
  - byte_idx 0..3 selects the lane: lane n = bits [8n+7:8n], first byte is bits [7:0].
  - byte_idx increments, 3 wraps to 0.
- State LOAD:
  - On the 4th byte accept, the complete word is evaluated next cycle in state COMMIT.
  - rx_break=1 clears byte_idx and the shift register. The partial word is discarded and the state stays LOAD. rx_break has priority over a same-cycle byte accept.
- State COMMIT (exactly 1 cycle):
  - Word == END_MARKER: no write; write_done<=1, core_rst<=0; go to DONE.
  - Otherwise: imem_we=1 for this cycle, imem_addr=current address, imem_wdata=word. Address and word_count increment after the write.
  - If the written address was DEPTH-1: overflow<=1, write_done<=1, core_rst<=0; go to DONE. The address never wraps.
  - Otherwise return to LOAD.
- Latency: imem_we is asserted exactly 1 cycle after the cycle the 4th byte is accepted.
- Bytes arriving during COMMIT: the next byte's rising edge is still sampled and accepted as lane 0 of the next word. UART byte spacing makes this rare, but it is required.
- State DONE: all rx inputs are ignored; imem_we=0; outputs hold. Only rst leaves DONE.
- Reset mid-load (rst=1 in any state): return to reset values next cycle. Partial word lost, address back to 0, core_rst=1.
- imem_addr is valid only while imem_we=1. It is held at the next write address otherwise.

Decomposition:
- Package uart_loader_pkg holds:
  - the state enum: LOAD, COMMIT, DONE;
  - END_MARKER default;
  - BYTES_PER_WORD=4.
- One sub-module, byte_assembler, does edge detect, byte_idx and the 32-bit shift/lane register. It outputs word and word_valid_pulse.
- The FSM, address counter and status flags stay in uart_imem_loader.

Test Plan:
- Bytes 13,01,01,FE then FF,FF,FF,FF -> imem_we one cycle later, addr 0, wdata 32'hFE010113. Then write_done=1, core_rst=0, word_count=1, no second write.
- Words 00000000, 00000000, 00812E23, then END_MARKER -> writes at addrs 0,1,2 with exact data, word_count=3, write_done=1, overflow=0.
- Bytes 93,07 then rx_break pulse, then 23,2E,81,00 -> single write at addr 0, wdata 32'h00812E23.
- ADDR_W=2; five non-marker words -> writes at addrs 0..3, overflow=1 and write_done=1 after the 4th write, 5th word ignored, imem_we stays 0.
- rx_valid held high for 20 cycles per byte -> exactly one accept per byte; 4 bytes give 1 write. rst asserted after 2 bytes of word 2 -> next cycle addr=0, word_count=0, core_rst=1; reload from addr 0 succeeds.
- Bytes after write_done -> no imem_we, outputs unchanged.
